serial_adder_seq: RTL and testbench

//  Parametrised bit-serial adder/subtractor with an integrated sequencer.
//  - A counter-driven FSM replaces the fixed 11-step enable chain of the previous generation.
//  - Accepts a start pulse, loads two WIDTH-bit operands and shifts them LSB-first through
//    one full adder with a carry flop.
//  - Reports result, carry and a busy/done handshake to the host logic in the serial-adder datapath.

---
 rtl/serial_adder_seq.sv | 140 ++++++++++++++
 tb/tb_serial_adder_seq.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_seq.sv
// serial_adder_seq
// Bit-serial adder/subtractor with a built-in sequencer. Two WIDTH-bit operands
// are loaded on request and shifted LSB-first through a single full adder and
// carry flop. The result is assembled MSB-first in a shift register, so it is
// correctly aligned once the last bit has been shifted in.
//
// Optional build macro:
//   SERIAL_ADD_OVF_EN  adds output ovf_o (signed overflow of the last operation).
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for start_i; sum_o/cout_o hold the previous result
// S_CLEAR | clear the sum shift register and carry (and overflow flag)
// S_LOAD  | capture operands, invert b_i and preset carry for subtraction
// S_SHIFT | one result bit per cycle, WIDTH cycles in total
// S_DONE  | one-cycle done_o pulse, result final
module serial_adder_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             sub_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
`ifdef SERIAL_ADD_OVF_EN
  output logic             cout_o,
  output logic             ovf_o
`else
  output logic             cout_o
`endif
);

  // Counter is one bit wider than strictly needed so it can step past WIDTH-1
  // without wrapping.
  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_SHIFT = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]       state_q;
  logic [2:0]       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic             bit_s;
  logic             bit_c;
  logic             last_shift;

  assign bit_s      = a_q[0] ^ b_q[0] ^ carry_q;
  assign bit_c      = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
  assign last_shift = (cnt_q == CNT_LAST);

  // Next-state decode; unused encodings fall back to idle.
  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE:  state_d = start_i ? S_CLEAR : S_IDLE;
      S_CLEAR: state_d = S_LOAD;
      S_LOAD:  state_d = S_SHIFT;
      S_SHIFT: state_d = last_shift ? S_DONE : S_SHIFT;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Operand shifters, result shifter, carry flop and bit counter.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      case (state_q)
        S_CLEAR: begin
          sum_q   <= '0;
          carry_q <= 1'b0;
        end
        S_LOAD: begin
          a_q     <= a_i;
          b_q     <= sub_i ? ~b_i : b_i;
          carry_q <= sub_i;
          cnt_q   <= '0;
        end
        S_SHIFT: begin
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          sum_q   <= {bit_s, sum_q[WIDTH-1:1]};
          carry_q <= bit_c;
          cnt_q   <= cnt_q + CNT_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

`ifdef SERIAL_ADD_OVF_EN
  logic ovf_q;

  // Signed overflow: carry into the MSB differs from carry out of the MSB.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ovf_q <= 1'b0;
    end else if (state_q == S_CLEAR) begin
      ovf_q <= 1'b0;
    end else if (state_q == S_SHIFT && last_shift) begin
      ovf_q <= carry_q ^ bit_c;
    end
  end

  assign ovf_o = ovf_q;
`endif

  assign busy_o = (state_q == S_CLEAR) || (state_q == S_LOAD) || (state_q == S_SHIFT);
  assign done_o = (state_q == S_DONE);
  assign sum_o  = sum_q;
  assign cout_o = carry_q;

endmodule

// File: tb/tb_serial_adder_seq.sv
// tb_serial_adder_seq
// Directed bench for serial_adder_seq at WIDTH=8, plus small WIDTH=16 and
// WIDTH=2 instances. Define SERIAL_ADD_OVF_EN to also check ovf_o.
`timescale 1ns/1ps
module tb_serial_adder_seq;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic        sub_i;
  logic [7:0]  a_i;
  logic [7:0]  b_i;
  logic        busy_o;
  logic        done_o;
  logic [7:0]  sum_o;
  logic        cout_o;

  logic        st16;
  logic        sub16;
  logic [15:0] a16;
  logic [15:0] b16;
  logic        busy16;
  logic        done16;
  logic [15:0] sum16;
  logic        cout16;

  logic        st2;
  logic        sub2;
  logic [1:0]  a2;
  logic [1:0]  b2;
  logic        busy2;
  logic        done2;
  logic [1:0]  sum2;
  logic        cout2;

`ifdef SERIAL_ADD_OVF_EN
  logic        ovf_o;
  logic        ovf16;
  logic        ovf2;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  serial_adder_seq #(.WIDTH(8)) u_dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (start_i),
    .sub_i   (sub_i),
    .a_i     (a_i),
    .b_i     (b_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .sum_o   (sum_o),
`ifdef SERIAL_ADD_OVF_EN
    .cout_o  (cout_o),
    .ovf_o   (ovf_o)
`else
    .cout_o  (cout_o)
`endif
  );

  serial_adder_seq #(.WIDTH(16)) u_dut16 (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (st16),
    .sub_i   (sub16),
    .a_i     (a16),
    .b_i     (b16),
    .busy_o  (busy16),
    .done_o  (done16),
    .sum_o   (sum16),
`ifdef SERIAL_ADD_OVF_EN
    .cout_o  (cout16),
    .ovf_o   (ovf16)
`else
    .cout_o  (cout16)
`endif
  );

  serial_adder_seq #(.WIDTH(2)) u_dut2 (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (st2),
    .sub_i   (sub2),
    .a_i     (a2),
    .b_i     (b2),
    .busy_o  (busy2),
    .done_o  (done2),
    .sum_o   (sum2),
`ifdef SERIAL_ADD_OVF_EN
    .cout_o  (cout2),
    .ovf_o   (ovf2)
`else
    .cout_o  (cout2)
`endif
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One WIDTH=8 operation. done_o must be seen after 10 further rising edges
  // (WIDTH+2), busy_o for the 10 cycles before it. Operands are scrambled once
  // the load is over, and start_i may be re-pulsed mid-operation.
  task automatic run_op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic sub, input logic [7:0] exp_sum, input logic exp_cout,
                         input int repulse_at);
    int lat;
    int busy_cnt;
    lat      = -1;
    busy_cnt = 0;
    @(negedge clk_i);
    a_i = a; b_i = b; sub_i = sub; start_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    start_i = 1'b0;
    for (int n = 0; n < 40 && lat < 0; n++) begin
      if (n > 0) @(negedge clk_i);
      if (n == 3) begin a_i = ~a; b_i = a ^ b; sub_i = ~sub; end
      start_i = (n == repulse_at);
      if (busy_o) busy_cnt++;
      if (done_o) lat = n;
    end
    start_i = 1'b0;
    check_eq({tag, " latency"}, lat, 10);
    check_eq({tag, " busy cycles"}, busy_cnt, 10);
    check_eq({tag, " sum"}, sum_o, exp_sum);
    check_eq({tag, " cout"}, cout_o, exp_cout);
`ifdef SERIAL_ADD_OVF_EN
    begin
      logic [7:0] bb;
      bb = sub ? ~b : b;
      check_eq({tag, " ovf"}, ovf_o, (a[7] == bb[7]) && (exp_sum[7] != a[7]));
    end
`endif
    @(negedge clk_i);
    check_eq({tag, " done one cycle"}, done_o, 1'b0);
    check_eq({tag, " idle after done"}, busy_o, 1'b0);
  endtask

  task automatic run_w16(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] exp_sum, input logic exp_cout);
    int lat;
    lat = -1;
    @(negedge clk_i);
    a16 = a; b16 = b; st16 = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    st16 = 1'b0;
    for (int n = 0; n < 60 && lat < 0; n++) begin
      if (n > 0) @(negedge clk_i);
      if (done16) lat = n;
    end
    check_eq("w16 latency", lat, 18);
    check_eq("w16 sum", sum16, exp_sum);
    check_eq("w16 cout", cout16, exp_cout);
    check_eq("w16 busy at done", busy16, 1'b0);
`ifdef SERIAL_ADD_OVF_EN
    check_eq("w16 ovf", ovf16, (a[15] == b[15]) && (exp_sum[15] != a[15]));
`endif
  endtask

  task automatic run_w2(input logic [1:0] a, input logic [1:0] b, input logic sub,
                        input logic [1:0] exp_sum, input logic exp_cout, input logic exp_ovf);
    int lat;
    lat = -1;
    @(negedge clk_i);
    a2 = a; b2 = b; sub2 = sub; st2 = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    st2 = 1'b0;
    for (int n = 0; n < 20 && lat < 0; n++) begin
      if (n > 0) @(negedge clk_i);
      if (done2) lat = n;
    end
    check_eq("w2 latency", lat, 4);
    check_eq("w2 sum", sum2, exp_sum);
    check_eq("w2 cout", cout2, exp_cout);
    check_eq("w2 busy at done", busy2, 1'b0);
`ifdef SERIAL_ADD_OVF_EN
    check_eq("w2 ovf", ovf2, exp_ovf);
`else
    check_eq("w2 done high", done2, exp_ovf | 1'b1);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int first;
    int second;
    rst_i = 1'b0; start_i = 1'b0; sub_i = 1'b0; a_i = '0; b_i = '0;
    st16 = 1'b0; sub16 = 1'b0; a16 = '0; b16 = '0;
    st2 = 1'b0; sub2 = 1'b0; a2 = '0; b2 = '0;
    repeat (3) @(negedge clk_i);
    check_eq("reset busy", busy_o, 1'b0);
    check_eq("reset done", done_o, 1'b0);
    check_eq("reset sum", sum_o, 8'h00);
    check_eq("reset cout", cout_o, 1'b0);
`ifdef SERIAL_ADD_OVF_EN
    check_eq("reset ovf", ovf_o, 1'b0);
`endif
    rst_i = 1'b1;

    run_op8("add 5a+3c", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, -1);
    run_op8("add ff+01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, -1);
    run_op8("sub 10-01", 8'h10, 8'h01, 1'b1, 8'h0F, 1'b1, -1);
    run_op8("sub 01-02", 8'h01, 8'h02, 1'b1, 8'hFF, 1'b0, -1);
    run_op8("add 7f+01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, -1);
    run_op8("sub 80-01", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, -1);
    run_op8("add 05+03", 8'h05, 8'h03, 1'b0, 8'h08, 1'b0, -1);

    // start_i pulsed while busy must be ignored and not queued
    run_op8("repulse", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 4);
    repeat (2) @(negedge clk_i);
    check_eq("repulse not queued", busy_o, 1'b0);

    // held start_i: one operation every WIDTH+4 cycles
    @(negedge clk_i);
    a_i = 8'h11; b_i = 8'h22; sub_i = 1'b0; start_i = 1'b1;
    first = -1; second = -1;
    for (int n = 0; n < 60 && second < 0; n++) begin
      @(negedge clk_i);
      if (done_o) begin
        if (first < 0) first = n;
        else second = n;
      end
    end
    start_i = 1'b0;
    check_eq("held start period", second - first, 12);
    check_eq("held start sum", sum_o, 8'h33);
    repeat (3) @(negedge clk_i);
    check_eq("held start released", busy_o, 1'b0);
    check_eq("hold sum in idle", sum_o, 8'h33);

    // asynchronous reset in the middle of the shift phase
    @(negedge clk_i);
    a_i = 8'h5A; b_i = 8'h3C; sub_i = 1'b0; start_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (6) @(negedge clk_i);
    check_eq("pre-reset partial sum", sum_o, 8'h60);
    rst_i = 1'b0;
    #1;
    check_eq("mid reset busy", busy_o, 1'b0);
    check_eq("mid reset done", done_o, 1'b0);
    check_eq("mid reset sum", sum_o, 8'h00);
    check_eq("mid reset cout", cout_o, 1'b0);
    @(negedge clk_i);
    rst_i = 1'b1;
    run_op8("after reset", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, -1);

    run_w16(16'hFFFF, 16'h0001, 16'h0000, 1'b1);
    run_w16(16'h1234, 16'h4321, 16'h5555, 1'b0);
    run_w2(2'd3, 2'd1, 1'b0, 2'd0, 1'b1, 1'b0);
    run_w2(2'd1, 2'd2, 1'b1, 2'd3, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
